// File: rtl/conv2d_0_filter_scheduler.sv
// Broadcasts 3-channel pixels to a bank of filter wrappers and gathers their results
// round-robin (filter 0..N-1 per output position) onto one valid/ready output stream.
module conv2d_0_filter_scheduler #(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned NUM_FILTERS = 8,
  parameter int unsigned NUM_PIX     = 12544,
  localparam int unsigned CNT_W      = $clog2(NUM_PIX + 1),
  localparam int unsigned SEL_W      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [DWIDTH*3-1:0]           s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DWIDTH*3-1:0]           f_in_data,
  output logic [NUM_FILTERS-1:0]        f_in_wrreq,
  input  logic [NUM_FILTERS-1:0]        f_in_full,
  input  logic [DWIDTH*NUM_FILTERS-1:0] f_out_data,
  output logic [NUM_FILTERS-1:0]        f_out_rdreq,
  input  logic [NUM_FILTERS-1:0]        f_out_empty,
  output logic [DWIDTH-1:0]             m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [SEL_W-1:0]              m_filter_idx,
  output logic                          m_last
);

  localparam logic [CNT_W-1:0] PIX_MAX  = CNT_W'(NUM_PIX);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(NUM_PIX - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t             r_state;
  state_t             w_state_d;
  logic [CNT_W-1:0]   r_in_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [SEL_W-1:0]   r_sel;
  logic               r_pending;
  logic [DWIDTH-1:0]  r_m_data;
  logic [SEL_W-1:0]   r_m_idx;
  logic               r_m_valid;
  logic               r_m_last;

  logic               w_run;
  logic               w_s_ready;
  logic               w_wr;
  logic               w_rd;
  logic [DWIDTH-1:0]  w_sel_data;
  logic               w_sel_empty;

  assign w_run     = (r_state == StRun);
  assign w_s_ready = w_run && (r_in_cnt < PIX_MAX) && (f_in_full == '0);
  assign w_wr      = s_valid && w_s_ready;

  always_comb begin
    w_sel_data  = '0;
    w_sel_empty = 1'b1;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      if (r_sel == SEL_W'(k)) begin
        w_sel_data  = f_out_data[k*DWIDTH +: DWIDTH];
        w_sel_empty = f_out_empty[k];
      end
    end
  end

  // Only one read in flight; the output slot must be free or draining this cycle.
  assign w_rd = w_run && !w_sel_empty && !r_pending && (!r_m_valid || m_ready) &&
                (r_out_cnt < PIX_MAX);

  always_comb begin
    f_out_rdreq = '0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      f_out_rdreq[k] = w_rd && (r_sel == SEL_W'(k));
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (r_m_valid && m_ready && r_m_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_sel     <= '0;
      r_pending <= 1'b0;
      r_m_data  <= '0;
      r_m_idx   <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && start) begin
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
        r_sel     <= '0;
        r_pending <= 1'b0;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end else begin
        if (w_wr && (r_in_cnt < PIX_MAX)) begin
          r_in_cnt <= r_in_cnt + CNT_W'(1);
        end
        r_pending <= w_rd;
        // FIFO data is valid the cycle after rdreq; a capture overrides a same-cycle drain.
        if (r_pending) begin
          r_m_data  <= w_sel_data;
          r_m_idx   <= r_sel;
          r_m_valid <= 1'b1;
          r_m_last  <= (r_out_cnt == PIX_LAST) && (r_sel == SEL_LAST);
          if (r_sel == SEL_LAST) begin
            r_sel     <= '0;
            r_out_cnt <= r_out_cnt + CNT_W'(1);
          end else begin
            r_sel <= r_sel + SEL_W'(1);
          end
        end else if (r_m_valid && m_ready) begin
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      end
    end
  end

  assign busy         = (r_state != StIdle);
  assign done         = (r_state == StDone);
  assign s_ready      = w_s_ready;
  assign f_in_data    = s_data;
  assign f_in_wrreq   = {NUM_FILTERS{w_wr}};
  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign m_filter_idx = r_m_idx;
  assign m_last       = r_m_last;

endmodule

// File: tb/tb_conv2d_0_filter_scheduler.sv
// Bench for conv2d_0_filter_scheduler: behavioural filter FIFOs, randomized traffic,
// scoreboard of expected gathered words checked by an independent output monitor.
module tb_conv2d_0_filter_scheduler;

  localparam int DW = 16;
  localparam int NF = 8;
  localparam int NP = 4;
  localparam int SW = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [3*DW-1:0]   s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [3*DW-1:0]   f_in_data;
  logic [NF-1:0]     f_in_wrreq;
  logic [NF-1:0]     f_in_full = '0;
  logic [DW*NF-1:0]  f_out_data = '0;
  logic [NF-1:0]     f_out_rdreq;
  logic [NF-1:0]     f_out_empty = '1;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [SW-1:0]     m_filter_idx;
  logic              m_last;

  conv2d_0_filter_scheduler #(.DWIDTH(DW), .NUM_FILTERS(NF), .NUM_PIX(NP)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .f_in_data(f_in_data), .f_in_wrreq(f_in_wrreq), .f_in_full(f_in_full),
    .f_out_data(f_out_data), .f_out_rdreq(f_out_rdreq), .f_out_empty(f_out_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_filter_idx(m_filter_idx), .m_last(m_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t            exp_q[$];
  logic [3*DW-1:0] pix_q[$];
  logic [DW-1:0]   fq[NF][$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_wr = 0;
  int n_frames = 0;
  int frame_acc = 0;
  int first_acc = 0;
  int last_acc = 0;

  int          valid_pct = 100;
  int          ready_pct = 100;
  int          full_pct = 0;
  int          empty_pct = 0;
  logic [NF-1:0] full_force = '0;
  logic [NF-1:0] stall_mask = '0;
  bit          force_valid = 1'b0;
  bit          mready_lo = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stand-in for a filter wrapper: one arbitrary function of the pixel per filter index.
  function automatic logic [DW-1:0] filt(input int k, input logic [3*DW-1:0] px);
    return (px[DW-1:0] + DW'(k * 16)) ^ px[3*DW-1:2*DW] ^ {px[2*DW-1:DW+8], 8'h00};
  endfunction

  function automatic logic [3*DW-1:0] rnd_pix();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[3*DW-1:0];
  endfunction

  task automatic push_frame(input bit directed);
    logic [3*DW-1:0] px;
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      px = directed ? {{(2*DW){1'b0}}, DW'(p)} : rnd_pix();
      pix_q.push_back(px);
      for (int k = 0; k < NF; k++) begin
        e.data = filt(k, px);
        e.idx  = SW'(k);
        e.last = (p == NP - 1) && (k == NF - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Negedge-latched handshakes, applied to the environment just after the next rising edge.
  logic [NF-1:0]   l_wr = '0;
  logic [NF-1:0]   l_rd = '0;
  logic [3*DW-1:0] l_sdata = '0;
  bit              l_acc = 1'b0;

  always @(posedge clock) begin
    #1;
    if (l_wr == '1) for (int k = 0; k < NF; k++) fq[k].push_back(filt(k, l_sdata));
    for (int k = 0; k < NF; k++) begin
      if (l_rd[k] && fq[k].size() > 0) f_out_data[k*DW +: DW] = fq[k].pop_front();
    end
    if (l_acc && pix_q.size() > 0) void'(pix_q.pop_front());
    if (!reset) begin
      for (int k = 0; k < NF; k++) fq[k].delete();
      pix_q.delete();
    end
    s_valid = force_valid || (pix_q.size() > 0 && $urandom_range(99) < valid_pct);
    s_data  = (pix_q.size() > 0) ? pix_q[0] : rnd_pix();
    f_in_full = full_force;
    for (int k = 0; k < NF; k++) begin
      if ($urandom_range(99) < full_pct) f_in_full[k] = 1'b1;
      f_out_empty[k] = (fq[k].size() == 0) || stall_mask[k] ||
                       ($urandom_range(99) < empty_pct);
    end
    m_ready = !mready_lo && ($urandom_range(99) < ready_pct);
  end

  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [SW-1:0] hold_i;
  logic          hold_l;
  int            post_last = 0;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    l_wr    = f_in_wrreq;
    l_rd    = f_out_rdreq;
    l_sdata = s_data;
    l_acc   = s_valid && s_ready;
    if (!reset) begin
      exp_q.delete();
      hold_v    = 1'b0;
      post_last = 0;
    end else begin
      if (f_in_wrreq != '0) begin
        check(f_in_wrreq == '1 && f_in_data == s_data && f_in_full == '0 && s_valid,
              "wr_broadcast", 64'(f_in_wrreq), 64'(8'hFF));
        if (f_in_wrreq == '1) n_wr++;
      end
      if (f_out_rdreq != '0) begin
        check($onehot(f_out_rdreq) && (f_out_rdreq & f_out_empty) == '0 &&
              !(m_valid && !m_ready), "rdreq_legal", 64'(f_out_rdreq), 64'(~f_out_empty));
      end
      if (hold_v) begin
        check(m_valid && m_data == hold_d && m_filter_idx == hold_i && m_last == hold_l,
              "hold_stable", 64'({m_valid, m_data}), 64'({1'b1, hold_d}));
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      hold_i = m_filter_idx;
      hold_l = m_last;
      if (post_last == 1) begin
        check(done && busy, "done_pulse", 64'({done, busy}), 64'(2'b11));
        post_last = 2;
      end else if (post_last == 2) begin
        check(!done && !busy, "idle_after_done", 64'({done, busy}), 64'(0));
        post_last = 0;
        n_frames++;
      end else if (done) begin
        check(1'b0, "spurious_done", 64'(done), 64'(0));
      end
      if (start && !busy) frame_acc = 0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", 64'(m_data), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check(m_data == e.data && m_filter_idx == e.idx && m_last == e.last, "word",
                64'({m_data, m_filter_idx, m_last}), 64'(e));
        end
        if (frame_acc > 0) check(cyc - last_acc >= 2, "throughput", 64'(cyc - last_acc), 64'(2));
        if (frame_acc == 0) first_acc = cyc;
        last_acc = cyc;
        frame_acc++;
        if (m_last) post_last = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_frame(input int tgt, input int budget);
    int i;
    for (i = 0; i < budget && n_frames < tgt; i++) tick();
    if (n_frames < tgt) begin
      check(1'b0, "frame_timeout", 64'(n_frames), 64'(tgt));
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
    end
    check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 400 && frame_acc < n; i++) tick();
    check(frame_acc >= n, "acc_progress", 64'(frame_acc), 64'(n));
  endtask

  function automatic bit outputs_zero();
    return !busy && !done && !s_ready && !m_valid && !m_last && f_in_wrreq == '0 &&
           f_out_rdreq == '0 && m_data == '0;
  endfunction

  initial begin
    int            wr0;
    int            tgt;
    bit            bad;
    logic [DW-1:0] d;

    repeat (3) tick();
    check(outputs_zero(), "reset_outputs", 64'({busy, done, s_ready, m_valid}), 64'(0));
    reset = 1'b1;
    tick();

    // Directed frame: continuous input, ready always high.
    push_frame(1'b1);
    wr0 = n_wr;
    tgt = n_frames + 1;
    pulse_start();
    for (int i = 0; i < 50 && pix_q.size() > 0; i++) tick();
    force_valid = 1'b1;
    tick();
    check(s_valid && !s_ready && f_in_wrreq == '0 && busy, "in_saturate",
          64'({s_ready, f_in_wrreq}), 64'(0));
    force_valid = 1'b0;
    check(n_wr - wr0 == NP, "wr_count", 64'(n_wr - wr0), 64'(NP));
    wait_frame(tgt, 400);
    check(last_acc - first_acc == 2 * (NP * NF - 1), "frame_cycles",
          64'(last_acc - first_acc), 64'(2 * (NP * NF - 1)));

    // Input backpressure from a single full filter FIFO.
    full_force = 8'h20;
    push_frame(1'b0);
    tgt = n_frames + 1;
    pulse_start();
    bad = 1'b0;
    repeat (6) begin
      tick();
      if (s_ready || f_in_wrreq != '0 || !s_valid) bad = 1'b1;
    end
    check(!bad, "full_blocks_input", 64'({s_ready, f_in_wrreq}), 64'(0));
    full_force = '0;
    wait_frame(tgt, 400);

    // Filter 3 output stalls: no reads to anyone while it is empty.
    stall_mask = 8'h08;
    push_frame(1'b1);
    tgt = n_frames + 1;
    pulse_start();
    wait_acc(3);
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (f_out_rdreq != '0) bad = 1'b1;
    end
    check(!bad, "stall_no_rdreq", 64'(f_out_rdreq), 64'(0));
    stall_mask = '0;
    wait_frame(tgt, 400);

    // Downstream stall with a word held.
    push_frame(1'b0);
    tgt = n_frames + 1;
    pulse_start();
    wait_acc(5);
    mready_lo = 1'b1;
    tick();
    for (int i = 0; i < 20 && !m_valid; i++) tick();
    d = m_data;
    bad = !m_valid;
    repeat (5) begin
      tick();
      if (!m_valid || m_data != d || f_out_rdreq != '0) bad = 1'b1;
    end
    check(!bad, "mready_hold", 64'({m_valid, m_data}), 64'({1'b1, d}));
    mready_lo = 1'b0;
    wait_frame(tgt, 400);

    // Reset mid-frame, then a clean frame from in_cnt=0.
    push_frame(1'b0);
    pulse_start();
    wait_acc(6);
    reset = 1'b0;
    tick();
    tick();
    check(outputs_zero(), "midframe_reset", 64'({busy, s_ready, m_valid, f_out_rdreq}), 64'(0));
    reset = 1'b1;
    tick();
    push_frame(1'b1);
    tgt = n_frames + 1;
    pulse_start();
    wait_frame(tgt, 400);

    // Randomized traffic.
    for (int f = 0; f < 10; f++) begin
      valid_pct = $urandom_range(100, 30);
      ready_pct = $urandom_range(100, 30);
      full_pct  = $urandom_range(30, 0);
      empty_pct = $urandom_range(30, 0);
      push_frame(1'b0);
      tgt = n_frames + 1;
      pulse_start();
      wait_frame(tgt, 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
